mem_arbiter: RTL and testbench

//  Shares the single 8-bit RAM port between the IF stage (32-bit instruction fetch)
//  and the MEM stage (1/2/4-byte load/store). Serialises each access into byte

---
 rtl/mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one byte-wide RAM port between instruction fetch and load/store,
// serialising each access into byte cycles and packing words little-endian.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_done,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din,
    output logic              if_rq,
    output logic              mem_rq
);

    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [2:0]        k_q, k_d;
    logic [2:0]        n_q, n_d;
    logic [3:0][7:0]   buf_q, buf_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              if_done_q, if_done_d;
    logic              mem_done_q, mem_done_d;
    logic [2:0]        mem_n;
    logic [3:0][7:0]   rd_merge;

    always_comb begin
        unique case (mem_len)
            2'b00:   mem_n = 3'd1;
            2'b01:   mem_n = 3'd2;
            default: mem_n = 3'd4;
        endcase
    end

    // Byte returned this cycle belongs to the address presented one cycle earlier.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign rd_merge[gi] = (k_q == 3'(gi + 1)) ? ram_din : buf_q[gi];
    end

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        k_d         = k_q;
        n_d         = n_q;
        buf_d       = buf_q;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        ram_a       = '0;
        ram_wr      = 1'b0;
        ram_dout    = 8'h00;
        unique case (state_q)
            IDLE: begin
                // The bubble after each completion lets the requester drop req first.
                if (!if_done_q && !mem_done_q) begin
                    if (mem_req) begin
                        state_d = mem_we ? MEM_WR : MEM_RD;
                        base_d  = mem_addr;
                        n_d     = mem_n;
                        k_d     = 3'd0;
                        buf_d   = mem_we ? mem_wdata : 32'h0;
                    end else if (if_req) begin
                        state_d = IF_RD;
                        base_d  = if_addr;
                        n_d     = 3'd4;
                        k_d     = 3'd0;
                        buf_d   = 32'h0;
                    end
                end
            end
            IF_RD, MEM_RD: begin
                ram_a = base_q + ADDR_W'(k_q);
                if (k_q != 3'd0) buf_d = rd_merge;
                if (state_q == IF_RD && !if_req) begin
                    state_d = IDLE;
                end else if (k_q == n_q) begin
                    state_d = IDLE;
                    if (state_q == IF_RD) begin
                        if_done_d = 1'b1;
                        if_data_d = rd_merge;
                    end else begin
                        mem_done_d  = 1'b1;
                        mem_rdata_d = rd_merge;
                    end
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            MEM_WR: begin
                ram_a    = base_q + ADDR_W'(k_q);
                ram_wr   = 1'b1;
                ram_dout = buf_q[k_q[1:0]];
                if (k_q == n_q - 3'd1) begin
                    state_d    = IDLE;
                    mem_done_d = 1'b1;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            k_q         <= 3'd0;
            n_q         <= 3'd0;
            buf_q       <= '0;
            if_data_q   <= 32'h0;
            mem_rdata_q <= 32'h0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            k_q         <= k_d;
            n_q         <= n_d;
            buf_q       <= buf_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign if_data   = if_data_q;
    assign mem_rdata = mem_rdata_q;
    assign if_done   = if_done_q;
    assign mem_done  = mem_done_q;
    assign if_rq     = if_req & ~if_done_q;
    assign mem_rq    = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-level reference of the arbitration and
// byte-serialisation rules checks every cycle; directed literals pin that reference.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [1:0]  mem_len;
    logic [31:0] if_data, mem_rdata, ram_a;
    logic        if_done, mem_done, ram_wr, if_rq, mem_rq;
    logic [7:0]  ram_dout, ram_din;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_data(if_data), .if_done(if_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_done(mem_done),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
        .if_rq(if_rq), .mem_rq(mem_rq)
    );

    // RAM: 4 KiB image indexed by the low address bits, one-cycle read latency.
    logic [7:0]  ram [0:4095];
    logic        pl_we;
    logic [11:0] pl_a;
    logic [7:0]  pl_d;
    always @(posedge clk) begin
        if (pl_we) ram[pl_a] <= pl_d;
        else if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
        ram_din <= ram[ram_a[11:0]];
    end

    function automatic logic [31:0] exp_read(input logic [31:0] b, input int n);
        logic [31:0] v;
        logic [31:0] a;
        v = 32'h0;
        for (int i = 0; i < n; i++) begin
            a = b + 32'(i);
            v[8*i +: 8] = ram[a[11:0]];
        end
        return v;
    endfunction

    // ---------------- reference model, compared every cycle ----------------
    int          m_chk = 0, m_pass = 0;
    bit          m_busy = 0, m_ifd = 0, m_md = 0;
    int          m_kind, m_n, m_t;
    logic [31:0] m_base, m_wdata, m_ifd_data, m_md_data;
    int          n_ifd = 0, n_md = 0, n_wr = 0;

    task automatic mchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        m_chk++;
        if (act === exp) m_pass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        bit nifd, nmd, exp_wr;
        int last;
        if (!rst) begin
            mchk("rst_ram_a", ram_a, 32'h0);
            mchk("rst_ram_wr", 32'(ram_wr), 32'h0);
            mchk("rst_ram_dout", 32'(ram_dout), 32'h0);
            mchk("rst_if_done", 32'(if_done), 32'h0);
            mchk("rst_mem_done", 32'(mem_done), 32'h0);
            mchk("rst_if_data", if_data, 32'h0);
            mchk("rst_mem_rdata", mem_rdata, 32'h0);
            m_busy = 0; m_ifd = 0; m_md = 0;
        end else begin
            mchk("if_done", 32'(if_done), 32'(m_ifd));
            mchk("mem_done", 32'(mem_done), 32'(m_md));
            if (m_ifd) mchk("if_data", if_data, m_ifd_data);
            if (m_md && m_kind == 1) mchk("mem_rdata", mem_rdata, m_md_data);
            exp_wr = m_busy && m_kind == 2 && m_t < m_n;
            mchk("ram_wr", 32'(ram_wr), 32'(exp_wr));
            if (m_busy && m_t < m_n) mchk("ram_a", ram_a, m_base + 32'(m_t));
            if (exp_wr) mchk("ram_dout", 32'(ram_dout), 32'(m_wdata[8*m_t +: 8]));
            mchk("if_rq", 32'(if_rq), 32'(if_req & ~m_ifd));
            mchk("mem_rq", 32'(mem_rq), 32'(mem_req & ~m_md));
            if (if_done) n_ifd++;
            if (mem_done) n_md++;
            if (ram_wr) n_wr++;
            // advance to the state after the coming rising edge
            nifd = 0; nmd = 0;
            if (m_busy) begin
                last = (m_kind == 2) ? m_n - 1 : m_n;
                if (m_kind == 0 && !if_req) m_busy = 0;
                else if (m_t == last) begin
                    m_busy = 0;
                    if (m_kind == 0) begin nifd = 1; m_ifd_data = exp_read(m_base, 4); end
                    else begin nmd = 1; m_md_data = exp_read(m_base, m_n); end
                end else m_t++;
            end else if (!m_ifd && !m_md) begin
                if (mem_req) begin
                    m_busy = 1; m_kind = mem_we ? 2 : 1; m_base = mem_addr; m_t = 0;
                    m_n = (mem_len == 2'b00) ? 1 : (mem_len == 2'b01) ? 2 : 4;
                    m_wdata = mem_wdata;
                end else if (if_req) begin
                    m_busy = 1; m_kind = 0; m_base = if_addr; m_t = 0; m_n = 4;
                end
            end
            m_ifd = nifd; m_md = nmd;
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    int d_chk = 0, d_pass = 0;

    task automatic dchk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        d_chk++;
        if (act === exp) d_pass++;
        else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    endtask

    task automatic load(input logic [11:0] a, input logic [7:0] d);
        pl_we = 1'b1; pl_a = a; pl_d = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
    endtask

    task automatic wait_for(input bit is_mem, output int cyc);
        bit got;
        cyc = 0; got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            cyc++;
            got = is_mem ? mem_done : if_done;
        end
        dchk(is_mem ? "mem_done_seen" : "if_done_seen", 32'(got), 32'h1);
    endtask

    task automatic start;
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc, w0, c0;
        rst = 1'b0; pl_we = 1'b0; pl_a = '0; pl_d = '0;
        if_req = 0; if_addr = 0; mem_req = 0; mem_we = 0; mem_len = 0;
        mem_addr = 0; mem_wdata = 0;
        @(posedge clk); #1;
        load(12'h100, 8'h13); load(12'h101, 8'h05); load(12'h102, 8'h10); load(12'h103, 8'h00);
        load(12'h200, 8'h11); load(12'h201, 8'h22); load(12'h202, 8'h33); load(12'h203, 8'h44);
        load(12'h302, 8'h77);
        load(12'hFFE, 8'h01); load(12'hFFF, 8'hA5); load(12'h000, 8'h02); load(12'h001, 8'h03);
        dchk("reset_ram_a", ram_a, 32'h0);
        dchk("reset_if_data", if_data, 32'h0);
        dchk("reset_done", {30'h0, if_done, mem_done}, 32'h0);
        rst = 1'b1;

        // 1: instruction fetch
        start(); if_req = 1; if_addr = 32'h100;
        wait_for(0, cyc);
        dchk("t1_cycles", 32'(cyc), 32'd6);
        dchk("t1_if_data", if_data, 32'h00100513);
        $display("txn IF read @00000100 data=%h cycles=%0d", if_data, cyc);
        if_req = 0;

        // 2: simultaneous requests, MEM wins
        start(); if_req = 1; if_addr = 32'h100;
        mem_req = 1; mem_we = 0; mem_len = 2'b10; mem_addr = 32'h200;
        wait_for(1, cyc);
        dchk("t2_mem_cycles", 32'(cyc), 32'd6);
        dchk("t2_mem_rdata", mem_rdata, 32'h44332211);
        dchk("t2_if_rq_held", 32'(if_rq), 32'h1);
        $display("txn MEM load4 @00000200 data=%h cycles=%0d", mem_rdata, cyc);
        mem_req = 0;
        wait_for(0, cyc);
        dchk("t2_if_after_mem", 32'(cyc), 32'd7);
        dchk("t2_if_data", if_data, 32'h00100513);
        $display("txn IF read @00000100 data=%h cycles=%0d", if_data, cyc);
        if_req = 0;

        // 3: half-word store
        start(); w0 = n_wr;
        mem_req = 1; mem_we = 1; mem_len = 2'b01; mem_addr = 32'h300; mem_wdata = 32'h1234BEEF;
        wait_for(1, cyc);
        dchk("t3_cycles", 32'(cyc), 32'd3);
        dchk("t3_wr_cycles", 32'(n_wr - w0), 32'd2);
        dchk("t3_ram300", 32'(ram[12'h300]), 32'hEF);
        dchk("t3_ram301", 32'(ram[12'h301]), 32'hBE);
        dchk("t3_ram302", 32'(ram[12'h302]), 32'h77);
        $display("txn MEM store2 @00000300 data=%h cycles=%0d", mem_wdata, cyc);
        mem_req = 0;

        // 4: address wrap, byte load then word fetch
        start(); mem_req = 1; mem_we = 0; mem_len = 2'b00; mem_addr = 32'hFFFFFFFF;
        wait_for(1, cyc);
        dchk("t4_byte_rdata", mem_rdata, 32'h000000A5);
        $display("txn MEM load1 @ffffffff data=%h cycles=%0d", mem_rdata, cyc);
        mem_req = 0;
        start(); if_req = 1; if_addr = 32'hFFFFFFFE;
        wait_for(0, cyc);
        dchk("t4_wrap_if_data", if_data, 32'h0302A501);
        $display("txn IF read @fffffffe data=%h cycles=%0d", if_data, cyc);
        if_req = 0;

        // 5: fetch abort, then immediate MEM acceptance
        start(); c0 = n_ifd; if_req = 1; if_addr = 32'h100;
        repeat (3) begin @(posedge clk); #1; end
        if_req = 0;
        @(posedge clk); #1;
        mem_req = 1; mem_we = 0; mem_len = 2'b00; mem_addr = 32'h200;
        wait_for(1, cyc);
        dchk("t5_mem_cycles", 32'(cyc), 32'd3);
        dchk("t5_mem_rdata", mem_rdata, 32'h00000011);
        dchk("t5_no_if_done", 32'(n_ifd - c0), 32'd0);
        $display("txn IF abort then MEM load1 @00000200 data=%h cycles=%0d", mem_rdata, cyc);
        mem_req = 0;

        // 6: reset during a store, then re-issue
        start(); c0 = n_md;
        mem_req = 1; mem_we = 1; mem_len = 2'b10; mem_addr = 32'h400; mem_wdata = 32'hCAFEF00D;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0; #1;
        dchk("t6_rst_ram_wr", 32'(ram_wr), 32'h0);
        dchk("t6_rst_ram_a", ram_a, 32'h0);
        dchk("t6_rst_ram_dout", 32'(ram_dout), 32'h0);
        dchk("t6_rst_if_data", if_data, 32'h0);
        dchk("t6_rst_mem_rdata", mem_rdata, 32'h0);
        mem_req = 0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        dchk("t6_no_mem_done", 32'(n_md - c0), 32'd0);
        $display("txn MEM store4 @00000400 dropped by reset");
        start(); mem_req = 1;
        wait_for(1, cyc);
        dchk("t6_cycles", 32'(cyc), 32'd5);
        dchk("t6_ram_word", {ram[12'h403], ram[12'h402], ram[12'h401], ram[12'h400]}, 32'hCAFEF00D);
        $display("txn MEM store4 @00000400 data=%h cycles=%0d", mem_wdata, cyc);
        mem_req = 0;
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", d_pass + m_pass, d_chk + m_chk);
        $finish;
    end

endmodule
